// File: rtl/mem_pkg.sv
// Shared types for the memory responder and the control-FSM decoder:
// access-width encoding (RISC-V funct3), responder FSM states and a
// helper that maps a width code onto its access size in bytes.
package mem_pkg;

    typedef enum logic [2:0] {
        BITS8   = 3'b000,
        BITS16  = 3'b001,
        BITS32  = 3'b010,
        BITS8U  = 3'b100,
        BITS16U = 3'b101
    } MemWidth;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_WAIT    = 2'd1,
        RS_ACCESS  = 2'd2,
        RS_RESPOND = 2'd3
    } MemRespState;

    // Access size in bytes; invalid codes report 1 (they are rejected anyway).
    function automatic logic [2:0] width_bytes(MemWidth w);
        case (w)
            BITS8, BITS8U:   return 3'd1;
            BITS16, BITS16U: return 3'd2;
            BITS32:          return 3'd4;
            default:         return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one 32-bit little-endian word.
// Load path: picks the addressed lane(s) and sign/zero extends.
// Store path: merges the low bytes of wdata into the old word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  width_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    // Shift the addressed byte down to lane 0, then extend / merge by width
    always_comb begin
        sh   = {off_i, 3'b000};
        lane = word_i >> sh;
        case (width_i)
            BITS8:   begin ld_data_o = {{24{lane[7]}}, lane[7:0]};   mask = 32'h0000_00FF; end
            BITS16:  begin ld_data_o = {{16{lane[15]}}, lane[15:0]}; mask = 32'h0000_FFFF; end
            BITS32:  begin ld_data_o = lane;                         mask = 32'hFFFF_FFFF; end
            BITS8U:  begin ld_data_o = {24'h0, lane[7:0]};           mask = 32'h0000_00FF; end
            BITS16U: begin ld_data_o = {16'h0, lane[15:0]};          mask = 32'h0000_FFFF; end
            default: begin ld_data_o = 32'h0;                        mask = 32'h0;         end
        endcase
        st_word_o = (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the load/store path: valid/ready request,
// WAIT_CYCLES wait states, one ACCESS cycle, registered one-cycle response.
// Optional: MEM_RESPONDER_MISALIGNED_EN lets misaligned H/W accesses
// through; those that cross a word boundary take a second ACCESS cycle.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WORDS       = 16383,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(4 * WORDS);

    localparam logic [1:0] S_IDLE    = RS_IDLE;
    localparam logic [1:0] S_WAIT    = RS_WAIT;
    localparam logic [1:0] S_ACCESS  = RS_ACCESS;
    localparam logic [1:0] S_RESPOND = RS_RESPOND;

    logic [31:0] mem [WORDS];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [2:0]    width_q, width_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [2:0]    size;
    logic [32:0]   end_addr;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [31:0]   rd_lo;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;
    logic [1:0]    al_off;
    logic [31:0]   al_word;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;

`ifdef MEM_RESPONDER_MISALIGNED_EN
    logic          phase_q, phase_d;
    logic          cross;
    logic [AW-1:0] idx_hi;
    logic [31:0]   rd_hi;
    logic [4:0]    sh;
    logic [63:0]   pair, pair_sh, mask64, merged64;
`endif

    assign idx   = addr_q[AW+1:2];
    assign rd_lo = mem[idx];

    // Reject out-of-range, invalid-width, unsigned-store and (by default) misaligned accesses
    always_comb begin
        size     = width_bytes(MemWidth'(width_q));
        end_addr = {1'b0, addr_q} + {30'h0, size} - 33'd1;
        acc_err  = (end_addr >= MEM_BYTES)
                 || !(width_q inside {BITS8, BITS16, BITS32, BITS8U, BITS16U})
                 || (write_q && (width_q == BITS8U || width_q == BITS16U));
`ifndef MEM_RESPONDER_MISALIGNED_EN
        acc_err  = acc_err
                 || (size == 3'd2 && addr_q[0])
                 || (size == 3'd4 && addr_q[1:0] != 2'b00);
`endif
    end

`ifdef MEM_RESPONDER_MISALIGNED_EN
    assign idx_hi = idx + AW'(1);
    assign rd_hi  = mem[idx_hi];

    // Word-crossing accesses are handled on the two-word window {hi, lo}
    always_comb begin
        cross    = ({1'b0, addr_q[1:0]} + size) > 3'd4;
        sh       = {addr_q[1:0], 3'b000};
        mask64   = (size == 3'd4) ? 64'hFFFF_FFFF : 64'h0000_FFFF;
        pair     = {rd_hi, rd_lo};
        pair_sh  = pair >> sh;
        merged64 = (pair & ~(mask64 << sh)) | (({32'h0, wdata_q} & mask64) << sh);
        al_off   = cross ? 2'b00 : addr_q[1:0];
        al_word  = cross ? pair_sh[31:0] : rd_lo;
    end
`else
    assign al_off  = addr_q[1:0];
    assign al_word = rd_lo;
`endif

    mem_lane_align u_align (
        .off_i     (al_off),
        .width_i   (width_q),
        .word_i    (al_word),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    // FSM next state, request latch, memory write request and response formation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        width_d      = width_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = 32'h0;
        err_d        = 1'b0;
        mem_we       = 1'b0;
        mem_widx     = idx;
        mem_wdata    = st_word;
`ifdef MEM_RESPONDER_MISALIGNED_EN
        phase_d      = phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    width_d = req_width;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACCESS;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_ACCESS: begin
                if (acc_err) begin
                    resp_valid_d = 1'b1;
                    err_d        = 1'b1;
                    state_d      = S_RESPOND;
                end
`ifdef MEM_RESPONDER_MISALIGNED_EN
                else if (cross && !phase_q) begin
                    // first half: low word; store commits its low part now
                    phase_d   = 1'b1;
                    mem_we    = write_q;
                    mem_wdata = merged64[31:0];
                end else if (cross) begin
                    phase_d      = 1'b0;
                    mem_we       = write_q;
                    mem_widx     = idx_hi;
                    mem_wdata    = merged64[63:32];
                    rdata_d      = write_q ? 32'h0 : ld_data;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESPOND;
                end
`endif
                else begin
                    mem_we       = write_q;
                    rdata_d      = write_q ? 32'h0 : ld_data;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESPOND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            width_q      <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
`ifdef MEM_RESPONDER_MISALIGNED_EN
            phase_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            width_q      <= width_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef MEM_RESPONDER_MISALIGNED_EN
            phase_q      <= phase_d;
`endif
        end
    end

    // Storage keeps its contents across reset; no write while reset is held
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_widx] <= mem_wdata;
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=1): loads/stores with
// hand-computed results, error cases, held req_valid, reset mid-request.
module tb_mem_responder;

    localparam int WORDS = 16383;
    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; lat counts cycles from the handshake cycle to the
    // response cycle. With hold=1, req_valid stays high until the response.
    task automatic do_req(input logic wr, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] d, input bit hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int  n;
        bit  got;
        n = 0;
        while (!req_ready && n < 10) begin step(); n++; end
        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = wr; req_width = w; req_addr = a; req_wdata = d;
        step();
        if (!hold) begin
            req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h0BAD_0BAD;
        end
        lat = 1; got = 1'b0; rd = 32'hXXXX_XXXX; er = 1'bx;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            lat++;
            if (resp_valid) begin
                got = 1'b1; rd = resp_rdata; er = resp_err;
            end else if (hold) begin
                check("busy_not_ready", {31'h0, req_ready}, 32'h0);
            end
        end
        check("resp_seen", {31'h0, got}, 32'h1);
        req_valid = 1'b0;
        step();
        check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
        check("ready_after_resp", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          pulses;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_width = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0;
        step(); step();
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_req_ready",  {31'h0, req_ready},  32'h0);
        check("rst_rdata",      resp_rdata,          32'h0);
        check("rst_err",        {31'h0, resp_err},   32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        dut.mem[32]        = 32'h1122_3344;
        dut.mem[30]        = 32'hAABB_CCDD;
        dut.mem[16]        = 32'hCAFE_BABE;
        dut.mem[WORDS-1]   = 32'h5A5A_A5A5;

        // LW 0x80
        do_req(1'b0, 3'b010, 32'h80, 32'h0, 1'b0, rd, er, lat);
        check("lw80_data", rd, 32'h1122_3344);
        check("lw80_err",  {31'h0, er}, 32'h0);
        check("lw80_lat",  lat, 32'd3);

        // byte 0x81 = F0
        dut.mem[32] = 32'h1122_F044;
        do_req(1'b0, 3'b000, 32'h81, 32'h0, 1'b0, rd, er, lat);
        check("lb81", rd, 32'hFFFF_FFF0);
        do_req(1'b0, 3'b100, 32'h81, 32'h0, 1'b0, rd, er, lat);
        check("lbu81", rd, 32'h0000_00F0);
        do_req(1'b0, 3'b001, 32'h80, 32'h0, 1'b0, rd, er, lat);
        check("lh80", rd, 32'hFFFF_F044);
        do_req(1'b0, 3'b101, 32'h80, 32'h0, 1'b0, rd, er, lat);
        check("lhu80", rd, 32'h0000_F044);
        do_req(1'b0, 3'b001, 32'h82, 32'h0, 1'b0, rd, er, lat);
        check("lh82", rd, 32'h0000_1122);

        // stores into word @0x78
        do_req(1'b1, 3'b001, 32'h7A, 32'h0000_1234, 1'b0, rd, er, lat);
        check("sh7a_rdata", rd, 32'h0);
        check("sh7a_err",   {31'h0, er}, 32'h0);
        check("sh7a_mem",   dut.mem[30], 32'h1234_CCDD);
        do_req(1'b1, 3'b000, 32'h78, 32'hFFFF_FF58, 1'b0, rd, er, lat);
        check("sb78_mem", dut.mem[30], 32'h1234_CC58);
        do_req(1'b0, 3'b010, 32'h78, 32'h0, 1'b0, rd, er, lat);
        check("lw78", rd, 32'h1234_CC58);

        // upper address boundary
        do_req(1'b0, 3'b010, 32'(4*WORDS-4), 32'h0, 1'b0, rd, er, lat);
        check("lw_last_data", rd, 32'h5A5A_A5A5);
        check("lw_last_err",  {31'h0, er}, 32'h0);
        do_req(1'b0, 3'b000, 32'(4*WORDS-1), 32'h0, 1'b0, rd, er, lat);
        check("lb_lastbyte", rd, 32'h0000_005A);
        do_req(1'b0, 3'b010, 32'(4*WORDS), 32'h0, 1'b0, rd, er, lat);
        check("lw_oob_err",   {31'h0, er}, 32'h1);
        check("lw_oob_rdata", rd, 32'h0);
        do_req(1'b0, 3'b000, 32'(4*WORDS), 32'h0, 1'b0, rd, er, lat);
        check("lb_oob_err", {31'h0, er}, 32'h1);
        do_req(1'b1, 3'b001, 32'(4*WORDS-2), 32'h0000_7777, 1'b0, rd, er, lat);
        check("sh_last_err", {31'h0, er}, 32'h0);
        check("sh_last_mem", dut.mem[WORDS-1], 32'h7777_A5A5);

        // illegal widths, with req_valid held through the whole transaction
        do_req(1'b1, 3'b100, 32'h40, 32'h1111_1111, 1'b1, rd, er, lat);
        check("sw_w100_err", {31'h0, er}, 32'h1);
        check("sw_w100_lat", lat, 32'd3);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin step(); if (resp_valid) pulses++; end
        check("held_no_reaccept", pulses, 32'd0);
        check("sw_w100_mem", dut.mem[16], 32'hCAFE_BABE);
        do_req(1'b1, 3'b011, 32'h40, 32'h2222_2222, 1'b0, rd, er, lat);
        check("sw_w011_err", {31'h0, er}, 32'h1);
        check("sw_w011_mem", dut.mem[16], 32'hCAFE_BABE);
        do_req(1'b0, 3'b111, 32'h40, 32'h0, 1'b0, rd, er, lat);
        check("l_w111_err",   {31'h0, er}, 32'h1);
        check("l_w111_rdata", rd, 32'h0);

        // misaligned word crossing 0x7C/0x80
        dut.mem[31] = 32'h0201_0000;
        dut.mem[32] = 32'h1122_0403;
        do_req(1'b0, 3'b010, 32'h7E, 32'h0, 1'b0, rd, er, lat);
`ifdef MEM_RESPONDER_MISALIGNED_EN
        check("lw7e_data", rd, 32'h0403_0201);
        check("lw7e_err",  {31'h0, er}, 32'h0);
        check("lw7e_lat",  lat, 32'd4);
`else
        check("lw7e_err",   {31'h0, er}, 32'h1);
        check("lw7e_rdata", rd, 32'h0);
        check("lw7e_lat",   lat, 32'd3);
        do_req(1'b1, 3'b001, 32'h7F, 32'h0000_9999, 1'b0, rd, er, lat);
        check("sh7f_err", {31'h0, er}, 32'h1);
        check("sh7f_mem", dut.mem[32], 32'h1122_0403);
`endif

        // reset while a store waits
        req_valid = 1'b1; req_write = 1'b1; req_width = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h1234_5678;
        check("sw40_ready", {31'h0, req_ready}, 32'h1);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("midrst_ready",      {31'h0, req_ready},  32'h0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", {31'h0, req_ready}, 32'h1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin step(); if (resp_valid) pulses++; end
        check("midrst_no_resp", pulses, 32'd0);
        check("midrst_mem", dut.mem[16], 32'hCAFE_BABE);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, er, lat);
        check("lw40_after_rst", rd, 32'hCAFE_BABE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
